scv_rominit: RTL and testbench

//  Upstream of the scv core: converts the host ioctl download stream into the core's ROMINIT_* write bus.

---
 rtl/scv_rominit_pkg.sv | 21 ++
 rtl/scv_rominit_if.sv | 35 +++
 rtl/scv_rominit_pow2_ceil.sv | 22 ++
 rtl/scv_rominit.sv | 182 ++++++++++++++++++
 tb/tb_scv_rominit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scv_rominit_pkg.sv
// Shared types and constants for the ioctl-to-ROMINIT download bridge.
package scv_rominit_pkg;

    typedef enum logic [1:0] {
        RI_IDLE,
        RI_LOAD,
        RI_PAD,
        RI_DONE
    } rominit_state_t;

    localparam logic [7:0] IDX_BIOS       = 8'd0;
    localparam logic [7:0] IDX_CART       = 8'd1;
    localparam int         CART_MIN_BYTES = 8192;
    localparam int         ADDR_W         = 25;
    localparam int         SIZE_W         = 18;

    function automatic logic idx_valid(input logic [7:0] idx);
        return (idx == IDX_BIOS) || (idx == IDX_CART);
    endfunction

endpackage

// File: rtl/scv_rominit_if.sv
// Host ioctl download port plus the core-facing ROMINIT write bus and status.
interface scv_rominit_if;
    import scv_rominit_pkg::*;

    logic              IOCTL_DOWNLOAD;
    logic [7:0]        IOCTL_INDEX;
    logic [ADDR_W-1:0] IOCTL_ADDR;
    logic [7:0]        IOCTL_DOUT;
    logic              IOCTL_WR;
    logic              IOCTL_WAIT;
    logic              ROMINIT_SEL_BOOT;
    logic              ROMINIT_SEL_CHR;
    logic              ROMINIT_SEL_CART;
    logic              ROMINIT_SEL_APU;
    logic [ADDR_W-1:0] ROMINIT_ADDR;
    logic [7:0]        ROMINIT_DATA;
    logic              ROMINIT_VALID;
    logic [SIZE_W-1:0] CART_BYTES;
    logic              SYS_RESB;

    modport slave (
        input  IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_ADDR, IOCTL_DOUT, IOCTL_WR,
        output IOCTL_WAIT, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
               ROMINIT_SEL_APU, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
               CART_BYTES, SYS_RESB
    );

    modport master (
        output IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_ADDR, IOCTL_DOUT, IOCTL_WR,
        input  IOCTL_WAIT, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
               ROMINIT_SEL_APU, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
               CART_BYTES, SYS_RESB
    );

endinterface

// File: rtl/scv_rominit_pow2_ceil.sv
// Combinational round-up of an 18-bit size to the next power of two.
module pow2_ceil
    import scv_rominit_pkg::*;
(
    input  logic [SIZE_W-1:0] value,
    output logic [SIZE_W-1:0] pow2
);

    logic [SIZE_W-1:0] m;

    // Smear the highest set bit of value-1 downward, then step to the next power.
    always_comb begin
        m    = value - SIZE_W'(1);
        m    = m | (m >> 1);
        m    = m | (m >> 2);
        m    = m | (m >> 4);
        m    = m | (m >> 8);
        m    = m | (m >> 16);
        pow2 = m + SIZE_W'(1);
    end

endmodule

// File: rtl/scv_rominit.sv
// Converts the host ioctl download stream into ROMINIT writes, pads short carts
// with 8'hFF up to a power of two and holds the core in reset while loading.
module scv_rominit
    import scv_rominit_pkg::*;
#(
    parameter int BOOT_BYTES = 4096,
    parameter int CHR_BYTES  = 1024,
    parameter int APU_BYTES  = 1024,
    parameter int CART_MAX   = 131072
) (
    input  logic         CLK,
    input  logic         RES,
    scv_rominit_if.slave bus
);

    localparam logic [ADDR_W-1:0] CHR_BASE = ADDR_W'(BOOT_BYTES);
    localparam logic [ADDR_W-1:0] APU_BASE = ADDR_W'(BOOT_BYTES + CHR_BYTES);
    localparam logic [ADDR_W-1:0] BIOS_END = ADDR_W'(BOOT_BYTES + CHR_BYTES + APU_BYTES);
    localparam logic [ADDR_W-1:0] CART_END = ADDR_W'(CART_MAX);
    localparam logic [SIZE_W-1:0] CART_CAP = SIZE_W'(CART_MAX);
    localparam logic [SIZE_W-1:0] CART_MIN = SIZE_W'(CART_MIN_BYTES);

    rominit_state_t    state_q, state_d;
    logic              dl_q;
    logic [7:0]        idx_q;
    logic [SIZE_W-1:0] hwm_q, p_q, pad_addr_q, cart_bytes_q;
    logic              phase_q, bios_ok_q, wait_q, resb_q;

    logic              valid_q, sel_boot_q, sel_chr_q, sel_apu_q, sel_cart_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    logic              valid_d, sel_boot_d, sel_chr_d, sel_apu_d, sel_cart_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;

    logic              rise, fall, start, is_cart, wr_acc, cart_in_range, pad_emit, pad_last;
    logic [SIZE_W-1:0] hwm_floor, pow2, p_calc, addr_plus1, hwm_next;

    assign rise          = bus.IOCTL_DOWNLOAD & ~dl_q;
    assign fall          = ~bus.IOCTL_DOWNLOAD & dl_q;
    assign start         = rise & idx_valid(bus.IOCTL_INDEX);
    assign is_cart       = (idx_q == IDX_CART);
    assign wr_acc        = (state_q == RI_LOAD) & bus.IOCTL_WR & bus.IOCTL_DOWNLOAD;
    assign cart_in_range = (bus.IOCTL_ADDR < CART_END);
    // A new download edge wins over the pending pad write.
    assign pad_emit      = (state_q == RI_PAD) & ~phase_q & ~rise;
    assign pad_last      = (pad_addr_q == p_q - SIZE_W'(1));

    assign addr_plus1    = bus.IOCTL_ADDR[SIZE_W-1:0] + SIZE_W'(1);
    assign hwm_next      = (addr_plus1 > hwm_q) ? addr_plus1 : hwm_q;
    assign hwm_floor     = (hwm_q < CART_MIN) ? CART_MIN : hwm_q;
    assign p_calc        = ((pow2 > CART_CAP) || (pow2 == '0)) ? CART_CAP : pow2;

    pow2_ceil u_pow2 (
        .value (hwm_floor),
        .pow2  (pow2)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) state_q <= RI_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RI_IDLE: if (start) state_d = RI_LOAD;
            RI_LOAD: begin
                if (fall)
                    state_d = (is_cart && (hwm_q != '0) && (hwm_q < p_calc)) ? RI_PAD : RI_DONE;
            end
            RI_PAD: begin
                if (rise)                       state_d = start ? RI_LOAD : RI_IDLE;
                else if (pad_emit && pad_last) state_d = RI_DONE;
            end
            RI_DONE: state_d = start ? RI_LOAD : RI_IDLE;
            default: state_d = RI_IDLE;
        endcase
    end

    always_comb begin
        valid_d    = 1'b0;
        sel_boot_d = 1'b0;
        sel_chr_d  = 1'b0;
        sel_apu_d  = 1'b0;
        sel_cart_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        if (wr_acc) begin
            data_d = bus.IOCTL_DOUT;
            if (is_cart) begin
                if (cart_in_range) begin
                    valid_d = 1'b1; sel_cart_d = 1'b1; addr_d = bus.IOCTL_ADDR;
                end
            end else if (bus.IOCTL_ADDR < CHR_BASE) begin
                valid_d = 1'b1; sel_boot_d = 1'b1; addr_d = bus.IOCTL_ADDR;
            end else if (bus.IOCTL_ADDR < APU_BASE) begin
                valid_d = 1'b1; sel_chr_d = 1'b1; addr_d = bus.IOCTL_ADDR - CHR_BASE;
            end else if (bus.IOCTL_ADDR < BIOS_END) begin
                valid_d = 1'b1; sel_apu_d = 1'b1; addr_d = bus.IOCTL_ADDR - APU_BASE;
            end
        end else if (pad_emit) begin
            valid_d = 1'b1; sel_cart_d = 1'b1;
            addr_d  = ADDR_W'(pad_addr_q);
            data_d  = 8'hFF;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            dl_q         <= 1'b0;
            idx_q        <= '0;
            hwm_q        <= '0;
            p_q          <= '0;
            pad_addr_q   <= '0;
            phase_q      <= 1'b0;
            bios_ok_q    <= 1'b0;
            cart_bytes_q <= '0;
            wait_q       <= 1'b1;
            resb_q       <= 1'b0;
        end else begin
            dl_q   <= bus.IOCTL_DOWNLOAD;
            wait_q <= (state_d == RI_PAD);
            if ((state_d == RI_LOAD) && (state_q != RI_LOAD)) begin
                idx_q <= bus.IOCTL_INDEX;
                hwm_q <= '0;
            end else if (wr_acc && is_cart && cart_in_range) begin
                hwm_q <= hwm_next;
            end
            if ((state_q == RI_LOAD) && fall) begin
                p_q        <= (hwm_q == '0) ? '0 : p_calc;
                pad_addr_q <= hwm_q;
                phase_q    <= 1'b0;
            end else if (state_q == RI_PAD) begin
                phase_q <= ~phase_q;
                if (pad_emit) pad_addr_q <= pad_addr_q + SIZE_W'(1);
            end
            if (state_q == RI_DONE) begin
                if (is_cart) cart_bytes_q <= p_q;
                else         bios_ok_q    <= 1'b1;
            end
            // Core reset releases only after a BIOS image has been seen.
            if ((state_d == RI_LOAD) || (state_d == RI_PAD))
                resb_q <= 1'b0;
            else if (state_q == RI_DONE)
                resb_q <= bios_ok_q | ~is_cart;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            valid_q    <= 1'b0;
            sel_boot_q <= 1'b0;
            sel_chr_q  <= 1'b0;
            sel_apu_q  <= 1'b0;
            sel_cart_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            sel_boot_q <= sel_boot_d;
            sel_chr_q  <= sel_chr_d;
            sel_apu_q  <= sel_apu_d;
            sel_cart_q <= sel_cart_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.IOCTL_WAIT       = wait_q;
    assign bus.SYS_RESB         = resb_q;
    assign bus.CART_BYTES       = cart_bytes_q;
    assign bus.ROMINIT_VALID    = valid_q;
    assign bus.ROMINIT_SEL_BOOT = sel_boot_q;
    assign bus.ROMINIT_SEL_CHR  = sel_chr_q;
    assign bus.ROMINIT_SEL_APU  = sel_apu_q;
    assign bus.ROMINIT_SEL_CART = sel_cart_q;
    assign bus.ROMINIT_ADDR     = addr_q;
    assign bus.ROMINIT_DATA     = data_q;

endmodule

// File: tb/tb_scv_rominit.sv
// Directed bench for scv_rominit: vector table for address mapping plus
// hand-written sequences for streaming, padding, abort and reset.
module tb_scv_rominit;
    import scv_rominit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scv_rominit_if bus ();

    scv_rominit dut (
        .CLK (clk),
        .RES (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [24:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] a;
        logic [7:0]  d;
        logic        ev;
        logic [3:0]  es;
        logic [24:0] ea;
    } vec_t;

    wr_t         log_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          sel_err  = 0;
    logic [31:0] cyc      = 0;
    logic [3:0]  sel;

    assign sel = {bus.ROMINIT_SEL_CART, bus.ROMINIT_SEL_APU, bus.ROMINIT_SEL_CHR, bus.ROMINIT_SEL_BOOT};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ROMINIT_VALID) begin
            log_q.push_back({sel, bus.ROMINIT_ADDR, bus.ROMINIT_DATA, cyc});
            if (!$onehot(sel)) sel_err <= sel_err + 1;
        end else if (sel != 4'd0) begin
            sel_err <= sel_err + 1;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'(i >> 8);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic open_dl(input logic [7:0] idx);
        tick();
        bus.IOCTL_INDEX    = idx;
        bus.IOCTL_DOWNLOAD = 1'b1;
        tick();
    endtask

    task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
        bus.IOCTL_ADDR = a;
        bus.IOCTL_DOUT = d;
        bus.IOCTL_WR   = 1'b1;
        tick();
        bus.IOCTL_WR   = 1'b0;
    endtask

    task automatic close_dl(input int budget, output int wait_cycles);
        int n;
        bus.IOCTL_DOWNLOAD = 1'b0;
        tick(2);
        n = 0;
        while (bus.IOCTL_WAIT && (n < budget)) begin
            tick();
            n++;
        end
        check("close_timeout", 64'(bus.IOCTL_WAIT), 64'd0);
        wait_cycles = n;
        tick(2);
    endtask

    initial begin
        vec_t vt[12];
        int   errs, npad, wcnt, n1, cur;
        wr_t  w;

        bus.IOCTL_DOWNLOAD = 1'b0;
        bus.IOCTL_INDEX    = 8'd0;
        bus.IOCTL_ADDR     = '0;
        bus.IOCTL_DOUT     = 8'd0;
        bus.IOCTL_WR       = 1'b0;

        vt[0]  = '{8'd0, 25'h0000000, 8'h5A, 1'b1, 4'b0001, 25'h000};
        vt[1]  = '{8'd0, 25'h0000FFF, 8'h3C, 1'b1, 4'b0001, 25'hFFF};
        vt[2]  = '{8'd0, 25'h0001000, 8'h01, 1'b1, 4'b0010, 25'h000};
        vt[3]  = '{8'd0, 25'h00013FF, 8'h02, 1'b1, 4'b0010, 25'h3FF};
        vt[4]  = '{8'd0, 25'h0001400, 8'h03, 1'b1, 4'b0100, 25'h000};
        vt[5]  = '{8'd0, 25'h00017FF, 8'h04, 1'b1, 4'b0100, 25'h3FF};
        vt[6]  = '{8'd0, 25'h0001800, 8'h05, 1'b0, 4'b0000, 25'h000};
        vt[7]  = '{8'd0, 25'h1FFFFFF, 8'h06, 1'b0, 4'b0000, 25'h000};
        vt[8]  = '{8'd1, 25'h0020000, 8'h07, 1'b0, 4'b0000, 25'h000};
        vt[9]  = '{8'd1, 25'h001FFFF, 8'hC3, 1'b1, 4'b1000, 25'h1FFFF};
        vt[10] = '{8'd1, 25'h0000000, 8'h81, 1'b1, 4'b1000, 25'h00000};
        vt[11] = '{8'd1, 25'h0001234, 8'h42, 1'b1, 4'b1000, 25'h01234};

        // Reset values
        tick(3);
        check("rst_wait", 64'(bus.IOCTL_WAIT), 64'd1);
        check("rst_resb", 64'(bus.SYS_RESB), 64'd0);
        check("rst_valid", 64'(bus.ROMINIT_VALID), 64'd0);
        check("rst_cart_bytes", 64'(bus.CART_BYTES), 64'd0);
        check("rst_sel", 64'(sel), 64'd0);
        rst = 1'b0;
        tick(2);
        check("idle_wait", 64'(bus.IOCTL_WAIT), 64'd0);

        // Invalid index: writes ignored, no wait
        log_q.delete();
        open_dl(8'd5);
        write_byte(25'h0, 8'h11);
        write_byte(25'h1, 8'h22);
        tick();
        check("idx5_wait", 64'(bus.IOCTL_WAIT), 64'd0);
        close_dl(100, wcnt);
        check("idx5_no_valid", 64'(log_q.size()), 64'd0);
        check("idx5_resb", 64'(bus.SYS_RESB), 64'd0);

        // Cart before any BIOS: exact 8192 bytes, no pad, core stays in reset
        open_dl(8'd1);
        write_byte(25'h1FFF, 8'hA5);
        check("pre_cart_ctl", 64'({bus.ROMINIT_VALID, sel}), 64'({1'b1, 4'b1000}));
        check("pre_cart_addr", 64'({bus.ROMINIT_ADDR, bus.ROMINIT_DATA}), 64'({25'h1FFF, 8'hA5}));
        close_dl(100, wcnt);
        check("pre_cart_bytes", 64'(bus.CART_BYTES), 64'd8192);
        check("pre_cart_resb", 64'(bus.SYS_RESB), 64'd0);

        // BIOS stream of 6144 back-to-back bytes
        log_q.delete();
        open_dl(8'd0);
        for (int i = 0; i < 6144; i++) begin
            write_byte(25'(i), pat(i));
            if (i == 100) check("bios_resb_low", 64'(bus.SYS_RESB), 64'd0);
        end
        tick();
        close_dl(100, wcnt);
        check("bios_resb_high", 64'(bus.SYS_RESB), 64'd1);
        check("bios_count", 64'(log_q.size()), 64'd6144);
        errs = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            w = log_q[k];
            if (k < 4096) begin
                if (w.sel != 4'b0001 || w.addr != 25'(k)) errs++;
            end else if (k < 5120) begin
                if (w.sel != 4'b0010 || w.addr != 25'(k - 4096)) errs++;
            end else begin
                if (w.sel != 4'b0100 || w.addr != 25'(k - 5120)) errs++;
            end
            if (w.data != pat(k)) errs++;
        end
        check("bios_map_errs", 64'(errs), 64'd0);

        // Mapping table, including overrun and out-of-window drops
        cur = -1;
        for (int i = 0; i < 12; i++) begin
            if (int'(vt[i].idx) != cur) begin
                if (cur >= 0) close_dl(100, wcnt);
                open_dl(vt[i].idx);
                cur = int'(vt[i].idx);
            end
            write_byte(vt[i].a, vt[i].d);
            check($sformatf("vec%0d_ctl", i), 64'({bus.ROMINIT_VALID, sel}), 64'({vt[i].ev, vt[i].es}));
            if (vt[i].ev)
                check($sformatf("vec%0d_addr_data", i), 64'({bus.ROMINIT_ADDR, bus.ROMINIT_DATA}),
                      64'({vt[i].ea, vt[i].d}));
        end
        close_dl(100, wcnt);
        check("vec_cart_bytes", 64'(bus.CART_BYTES), 64'd131072);
        check("vec_resb", 64'(bus.SYS_RESB), 64'd1);

        // Cart 24576 bytes padded to 32768
        log_q.delete();
        open_dl(8'd1);
        for (int i = 0; i < 24576; i++) begin
            write_byte(25'(i), pat(i));
            if (i == 10) check("c24k_resb_low", 64'(bus.SYS_RESB), 64'd0);
        end
        tick();
        close_dl(20000, wcnt);
        check("c24k_wait_during_pad", 64'(wcnt >= 16000), 64'd1);
        check("c24k_cart_bytes", 64'(bus.CART_BYTES), 64'd32768);
        check("c24k_count", 64'(log_q.size()), 64'(24576 + 8192));
        errs = 0;
        npad = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            w = log_q[k];
            if (w.sel != 4'b1000 || w.addr != 25'(k)) errs++;
            if (k < 24576) begin
                if (w.data != pat(k)) errs++;
            end else begin
                npad++;
                if (w.data != 8'hFF) errs++;
                if (k > 24576 && (w.cyc - log_q[k-1].cyc) != 32'd2) errs++;
            end
        end
        check("c24k_map_errs", 64'(errs), 64'd0);
        check("c24k_pad_n", 64'(npad), 64'd8192);
        check("c24k_resb", 64'(bus.SYS_RESB), 64'd1);

        // Cart 100 bytes padded up to the 8192 minimum
        log_q.delete();
        open_dl(8'd1);
        for (int i = 0; i < 100; i++) write_byte(25'(i), pat(i));
        tick();
        close_dl(20000, wcnt);
        check("c100_cart_bytes", 64'(bus.CART_BYTES), 64'd8192);
        check("c100_count", 64'(log_q.size()), 64'd8192);
        w = log_q[100];
        check("c100_first_pad", 64'({w.sel, w.addr, w.data}), 64'({4'b1000, 25'd100, 8'hFF}));
        w = log_q[log_q.size() - 1];
        check("c100_last_pad", 64'({w.sel, w.addr, w.data}), 64'({4'b1000, 25'd8191, 8'hFF}));

        // Empty cart: size 0, no padding
        log_q.delete();
        open_dl(8'd1);
        tick();
        close_dl(100, wcnt);
        check("c0_cart_bytes", 64'(bus.CART_BYTES), 64'd0);
        check("c0_no_writes", 64'(log_q.size()), 64'd0);
        check("c0_resb", 64'(bus.SYS_RESB), 64'd1);

        open_dl(8'd1);
        write_byte(25'h1FFF, 8'h5A);
        tick();
        close_dl(100, wcnt);
        check("c8k_cart_bytes", 64'(bus.CART_BYTES), 64'd8192);

        // Reassert download during PAD: padding stops, BIOS load proceeds
        open_dl(8'd1);
        write_byte(25'h1000, 8'h77);
        tick();
        bus.IOCTL_DOWNLOAD = 1'b0;
        tick(30);
        check("abort_pad_wait", 64'(bus.IOCTL_WAIT), 64'd1);
        bus.IOCTL_INDEX    = 8'd0;
        bus.IOCTL_DOWNLOAD = 1'b1;
        tick(2);
        check("abort_wait_low", 64'(bus.IOCTL_WAIT), 64'd0);
        check("abort_resb_low", 64'(bus.SYS_RESB), 64'd0);
        n1 = log_q.size();
        tick(10);
        check("abort_no_more_pad", 64'(log_q.size()), 64'(n1));
        write_byte(25'h5, 8'h99);
        check("abort_bios_ctl", 64'({bus.ROMINIT_VALID, sel}), 64'({1'b1, 4'b0001}));
        check("abort_bios_addr", 64'({bus.ROMINIT_ADDR, bus.ROMINIT_DATA}), 64'({25'h5, 8'h99}));
        tick();
        close_dl(100, wcnt);
        check("abort_resb_high", 64'(bus.SYS_RESB), 64'd1);
        check("abort_cart_bytes", 64'(bus.CART_BYTES), 64'd8192);

        // Reset in the middle of PAD
        open_dl(8'd1);
        write_byte(25'h1000, 8'h66);
        tick();
        bus.IOCTL_DOWNLOAD = 1'b0;
        tick(40);
        check("midpad_wait", 64'(bus.IOCTL_WAIT), 64'd1);
        rst = 1'b1;
        #2;
        check("res_wait", 64'(bus.IOCTL_WAIT), 64'd1);
        check("res_resb", 64'(bus.SYS_RESB), 64'd0);
        check("res_valid_sel", 64'({bus.ROMINIT_VALID, sel}), 64'd0);
        check("res_cart_bytes", 64'(bus.CART_BYTES), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("post_res_wait", 64'(bus.IOCTL_WAIT), 64'd0);
        open_dl(8'd1);
        tick();
        close_dl(100, wcnt);
        check("post_res_resb", 64'(bus.SYS_RESB), 64'd0);

        tick(2);
        check("select_rule_errs", 64'(sel_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
